// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg
// Shared constants and types for the RC5-16 key-schedule datapath.
//   W          : word width in bits
//   T          : expanded table size for the default 16 rounds
//   C          : number of key words (128-bit key / 16-bit words)
//   P16, Q16   : RC5 magic constants for 16-bit words
//   MIX_ITERS  : mixing iterations, 3*max(T,C)
//   ke_state_t : key_expand controller states
// ---------------------------------------------------------------------------
package rc5_pkg;

    localparam int          W         = 16;
    localparam int          T         = 34;
    localparam int          C         = 8;
    localparam logic [15:0] P16       = 16'hB7E1;
    localparam logic [15:0] Q16       = 16'h9E37;
    localparam int          MIX_ITERS = 102;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } ke_state_t;

endpackage

// File: rtl/key_expand_rotl.sv
// ---------------------------------------------------------------------------
// rotl
// Combinational left rotator of a W-bit word.
//   i_din   : word to rotate
//   i_shamt : rotate amount, 0..15
//   o_dout  : i_din rotated left by i_shamt
// ---------------------------------------------------------------------------
module rotl #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_din,
    input  logic [3:0]   i_shamt,
    output logic [W-1:0] o_dout
);

    logic [2*W-1:0] w_dbl;

    // Shift a doubled copy so the bits leaving the top re-enter at the bottom.
    always_comb begin
        w_dbl  = {i_din, i_din} << i_shamt;
        o_dout = w_dbl[2*W-1:W];
    end

endmodule

// File: rtl/key_expand.sv
// ---------------------------------------------------------------------------
// key_expand
// RC5-16 key schedule: expands a 128-bit user key into the S subkey table.
// One INIT write per cycle, then one mixing iteration per cycle.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : begin expansion (only honoured in IDLE)
//   key     : 128-bit user key, captured on acceptance
//   rd_addr : subkey read index
//   rd_data : S[rd_addr] when ready and in range, else 0 (combinational)
//   busy    : expansion in progress (INIT/MIX)
//   ready   : table holds a complete schedule
//   done    : one-cycle completion pulse
// ---------------------------------------------------------------------------
module key_expand
    import rc5_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [5:0]   rd_addr,
    output logic [15:0]  rd_data,
    output logic         busy,
    output logic         ready,
    output logic         done
);

    localparam int TT   = 2 * (ROUNDS + 1);
    localparam int NMIX = 3 * ((TT > C) ? TT : C);

    logic [W-1:0] r_s [TT];
    logic [W-1:0] r_l [C];
    ke_state_t    r_state;
    logic [5:0]   r_i;
    logic [2:0]   r_j;
    logic [7:0]   r_cnt;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_init_val;
    logic         r_busy;
    logic         r_ready;
    logic         r_done;

    logic [W-1:0] w_sum_a;
    logic [W-1:0] w_a_new;
    logic [W-1:0] w_sum_b;
    logic [W-1:0] w_ab;
    logic [W-1:0] w_b_new;
    logic [W-1:0] w_rd;

    // Mixing datapath: A' from S[i], then B' from L[j] using A'.
    always_comb begin
        w_sum_a = r_s[r_i] + r_a + r_b;
        w_sum_b = r_l[r_j] + w_a_new + r_b;
        w_ab    = w_a_new + r_b;
    end

    rotl #(.W(W)) u_rotl_a (
        .i_din   (w_sum_a),
        .i_shamt (4'd3),
        .o_dout  (w_a_new)
    );

    rotl #(.W(W)) u_rotl_b (
        .i_din   (w_sum_b),
        .i_shamt (w_ab[3:0]),
        .o_dout  (w_b_new)
    );

    // Controller, tables and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < TT; n++) r_s[n] <= '0;
            for (int n = 0; n < C; n++)  r_l[n] <= '0;
            r_state    <= ST_IDLE;
            r_i        <= 6'd0;
            r_j        <= 3'd0;
            r_cnt      <= 8'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_init_val <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int n = 0; n < C; n++) r_l[n] <= key[16*n +: 16];
                        r_a        <= '0;
                        r_b        <= '0;
                        r_i        <= 6'd0;
                        r_j        <= 3'd0;
                        r_cnt      <= 8'd0;
                        r_init_val <= P16;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    // r_init_val tracks P16 + k*Q16 incrementally.
                    r_s[r_i]   <= r_init_val;
                    r_init_val <= r_init_val + Q16;
                    if (r_i == 6'(TT - 1)) begin
                        r_i     <= 6'd0;
                        r_state <= ST_MIX;
                    end else begin
                        r_i <= r_i + 6'd1;
                    end
                end
                ST_MIX: begin
                    r_s[r_i] <= w_a_new;
                    r_l[r_j] <= w_b_new;
                    r_a      <= w_a_new;
                    r_b      <= w_b_new;
                    r_j      <= r_j + 3'd1;
                    r_i      <= (r_i == 6'(TT - 1)) ? 6'd0 : r_i + 6'd1;
                    r_cnt    <= r_cnt + 8'd1;
                    if (r_cnt == 8'(NMIX - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read port: only a complete schedule is ever exposed.
    always_comb begin
        w_rd = '0;
        if (r_ready && (rd_addr < 6'(TT))) begin
            w_rd = r_s[rd_addr];
        end else begin
            w_rd = '0;
        end
    end

    assign rd_data = w_rd;
    assign busy    = r_busy;
    assign ready   = r_ready;
    assign done    = r_done;

endmodule

// File: tb/tb_key_expand.sv
module tb_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [5:0]   rd_addr;
    logic [15:0]  rd_data;
    logic         busy;
    logic         ready;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    key_expand #(.ROUNDS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .ready   (ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rl16(input logic [15:0] x, input int n);
        logic [15:0] r;
        r = (n == 0) ? x : ((x << n) | (x >> (16 - n)));
        return r;
    endfunction

    // Reference RC5-16 key schedule; mix=0 gives the INIT-only table.
    function automatic logic [34*16-1:0] rc5_sched(input logic [127:0] k, input bit mix);
        logic [15:0] s [34];
        logic [15:0] l [8];
        logic [15:0] a, b, t;
        logic [34*16-1:0] res;
        int ii, jj;
        for (int n = 0; n < 34; n++) s[n] = 16'hB7E1 + 16'(n) * 16'h9E37;
        for (int n = 0; n < 8; n++)  l[n] = k[16*n +: 16];
        a = 16'd0; b = 16'd0; ii = 0; jj = 0;
        if (mix) begin
            for (int it = 0; it < 3 * 34; it++) begin
                t = s[ii] + a + b;
                a = rl16(t, 3);
                t = l[jj] + a + b;
                b = rl16(t, int'((a + b) % 16'd16));
                s[ii] = a;
                l[jj] = b;
                ii = (ii + 1) % 34;
                jj = (jj + 1) % 8;
            end
        end
        for (int n = 0; n < 34; n++) res[16*n +: 16] = s[n];
        return res;
    endfunction

    // Behavioural expectation: an accepted start yields done 137 cycles later.
    int               m_left;
    logic             m_done;
    logic             m_ready;
    logic [34*16-1:0] m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_ready <= 1'b0;
            m_exp   <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_ready <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else if (start && !m_done) begin
            m_left  <= 136;
            m_ready <= 1'b0;
            m_done  <= 1'b0;
            m_exp   <= rc5_sched(key, 1'b1);
        end else begin
            m_done <= 1'b0;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [5:0] a);
        logic [15:0] v;
        v = 16'h0000;
        if (m_ready && a < 6'd34) v = m_exp[16*a +: 16];
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy",    {31'd0, busy},  {31'd0, (m_left != 0)});
        chk("done",    {31'd0, done},  {31'd0, m_done});
        chk("ready",   {31'd0, ready}, {31'd0, m_ready});
        chk("rd_data", {16'd0, rd_data}, {16'd0, exp_rd(rd_addr)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_expand(input logic [127:0] k, input string tag);
        int n;
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        key   = ~k;
        n = 1;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 137);
        tick();
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            #1;
            if (a >= 34) chk({tag, "_oor"}, {16'd0, rd_data}, 32'h0000);
            else         chk({tag, "_rd"}, {16'd0, rd_data}, {16'd0, m_exp[16*a +: 16]});
            tick();
        end
        rd_addr = 6'd0;
    endtask

    initial begin
        logic [34*16-1:0] s0;
        int               t_done [$];
        int               cyc;
        rst = 1'b1; start = 1'b0; key = '0; rd_addr = 6'd0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_busy",  {31'd0, busy},  32'd0);
        chk("idle_ready", {31'd0, ready}, 32'd0);
        chk("idle_done",  {31'd0, done},  32'd0);
        chk("idle_rd",    {16'd0, rd_data}, 32'd0);

        // Pin the reference model's INIT table with hand-computed words.
        s0 = rc5_sched(128'd0, 1'b0);
        chk("model_s0",  {16'd0, s0[0*16 +: 16]},  32'hB7E1);
        chk("model_s1",  {16'd0, s0[1*16 +: 16]},  32'h5618);
        chk("model_s33", {16'd0, s0[33*16 +: 16]}, 32'h1CF8);

        run_expand(128'd0, "k0");
        sweep("k0");

        run_expand(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, "k1");
        sweep("k1");

        // start held high while the key keeps changing.
        start = 1'b1;
        cyc = 0;
        repeat (3 * 138 + 10) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            cyc++;
            if (done) t_done.push_back(cyc);
        end
        start = 1'b0;
        chk("held_num_done", t_done.size(), 3);
        for (int n = 1; n < t_done.size(); n++)
            chk("held_period", t_done[n] - t_done[n-1], 138);
        cyc = 0;
        while (busy && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("held_drain", {31'd0, busy}, 32'd0);
        tick();
        sweep("held");

        // Reset 60 cycles into an expansion.
        key   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_rd",    {16'd0, rd_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_expand(128'h00112233_44556677_8899AABB_CCDDEEFF, "post_rst");
        sweep("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL expose parameter ROUNDS, default 16: the maximum RC5 round count supported; table size T = 2*(ROUNDS+1) = 34.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the only reset; asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to expand the key; sampled only in IDLE.
REQ-005 SHALL have port key, input, 128 bits: user key; byte j = key[8j+7:8j].
REQ-006 SHALL have port rd_addr, input, 6 bits: subkey index for the downstream cipher core.
REQ-007 SHALL have port rd_data, output, 16 bits: combinational S[rd_addr].
REQ-008 SHALL have port busy, output, 1 bit: high while an expansion is in progress.
REQ-009 SHALL have port ready, output, 1 bit: high while the table holds a complete, valid schedule.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when an expansion completes.

Function
REQ-011 SHALL implement the states IDLE, INIT, MIX and DONE.
REQ-012 IDLE with start=1: SHALL load L[i] = key[16i+15:16i] for i = 0..7, clear A, B, i and j, clear ready, and move to INIT.
REQ-013 INIT: SHALL write one word per cycle, S[k] = P16 + k*Q16 mod 2^16 for k = 0..33, with P16 = 0xB7E1 and Q16 = 0x9E37; SHALL take 34 cycles, then move to MIX.
REQ-014 MIX: SHALL perform one iteration per cycle, 102 iterations (3*max(T,8)).
REQ-015 Each MIX iteration SHALL compute A' = rotl16(S[i]+A+B, 3), then B' = rotl16(L[j]+A'+B, (A'+B) mod 16).
REQ-016 Each MIX iteration SHALL write S[i] = A' and L[j] = B', and SHALL update i = (i+1) mod 34 and j = (j+1) mod 8.
REQ-017 All additions SHALL be 16-bit modulo 2^16, with carries discarded.
REQ-018 DONE: SHALL last 1 cycle with done=1 and ready=1, then return to IDLE; ready SHALL stay 1 until the next accepted start or reset.
REQ-019 Latency: if start is sampled at edge k, busy SHALL be 1 from edge k through edge k+136, and done SHALL be high in the cycle after edge k+136 (137 cycles total).
REQ-020 busy SHALL be 1 in INIT and MIX, and 0 in IDLE and DONE.
REQ-021 start while not in IDLE SHALL be ignored; key changes after acceptance SHALL NOT affect the result.
REQ-022 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-023 rd_data SHALL be 0 when ready=0 or rd_addr > 33; otherwise it SHALL equal S[rd_addr] with zero-cycle latency.
REQ-024 Wrap-around: after 102 iterations, i SHALL have visited each S index exactly 3 times and j each L index 12.75 times (iteration count is fixed, not j-bounded).

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, busy=0, ready=0, done=0, A=B=0, i=j=0, all S[*]=0 and all L[*]=0.
REQ-026 Reset mid-expansion SHALL abort it; the partial table SHALL NOT become visible, and rd_data SHALL read 0.
REQ-027 After reset deasserts, the first start SHALL behave exactly per REQ-012 to REQ-019.

Structure
REQ-028 Shared package rc5_pkg SHALL hold W=16, T=34, C=8, P16, Q16, MIX_ITERS=102 and the key_expand state enum.
REQ-029 SHALL instantiate the existing rotl rotator twice (fixed shift 3; variable shift), with no other sub-modules.
REQ-030 S SHALL be a 34x16 register array and L an 8x16 register array; no RAM macros.

Verification
REQ-031 Reset, then rst low for 5 cycles with no start -> busy=0, ready=0, done=0, rd_data=0 at rd_addr=0.
REQ-032 start pulse with key=0 -> done high exactly 137 cycles later, for 1 cycle; ready=1 afterwards; S[0..33] match the software RC5-16/16/16 key-schedule model bit-exactly.
REQ-033 Model variant with mixing disabled (INIT only) -> S[0]=0xB7E1, S[1]=0x5618, S[33]=0x1CF8.
REQ-034 start held high continuously, plus key toggled during busy -> only one done per 138-cycle period; result matches the key captured at acceptance.
REQ-035 rst asserted at cycle 60 of an expansion -> immediately busy=0, ready=0, rd_data=0; a new start yields correct results 137 cycles later.
REQ-036 ready=1, rd_addr swept 0..63 -> addresses 34..63 return 0x0000; addresses 0..33 return the model values.
